// File: rtl/clock_ctrl_if.sv
// Control/status bundle for clock_ctrl: mode/step/divider inputs and the CPU tick outputs.
interface clock_ctrl_if #(
    parameter int unsigned DIV_W = 21
);
    logic             run;
    logic             step;
    logic [DIV_W-1:0] div;
    logic             cpu_ce;
    logic             cpu_clk;
    logic [15:0]      ce_count;

    modport master (output run, step, div, input cpu_ce, cpu_clk, ce_count);
    modport slave  (input run, step, div, output cpu_ce, cpu_clk, ce_count);
endinterface

// File: rtl/clock_ctrl.sv
// CPU clock-enable generator: free-run divider or debounced single-step, plus LED clock and pulse count.
// Define CLKCTL_DEBOUNCE_EN to debounce the step button; otherwise the synchronised level is used directly.
module clock_ctrl #(
    parameter int unsigned DIV_W     = 21,
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    clock_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, PULSE, RELEASE} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       run_sync_q, run_sync_d;
    logic [1:0]       step_sync_q, step_sync_d;
    logic             step_db_prev_q, step_db_prev_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic [CNT_W-1:0] ce_count_q, ce_count_d;
    logic             run_s, step_s, step_db, step_rise;

    assign run_s     = run_sync_q[1];
    assign step_s    = step_sync_q[1];
    assign step_rise = step_db & ~step_db_prev_q;

`ifdef CLKCTL_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            step_db_q, step_db_d;

    // Accept a new button level only after it has differed for DB_CYCLES straight cycles
    always_comb begin
        db_cnt_d  = '0;
        step_db_d = step_db_q;
        if (step_s != step_db_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                step_db_d = step_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q  <= '0;
            step_db_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            step_db_q <= step_db_d;
        end
    end

    assign step_db = step_db_q;
`else
    logic unused_db_cfg;
    assign unused_db_cfg = ^(DB_W'(DB_CYCLES));
    assign step_db       = step_s;
`endif

    // Synchronisers, tick state machine and pulse side effects
    always_comb begin
        run_sync_d     = {run_sync_q[0], bus.run};
        step_sync_d    = {step_sync_q[0], bus.step};
        step_db_prev_d = step_db;
        state_d        = state_q;
        cnt_d          = cnt_q;
        cpu_ce_d       = 1'b0;
        cpu_clk_d      = cpu_clk_q;
        ce_count_d     = ce_count_q;

        if (cpu_ce_q) begin
            cpu_clk_d  = ~cpu_clk_q;
            ce_count_d = ce_count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (run_s) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (step_rise) begin
                    state_d  = PULSE;
                    cpu_ce_d = 1'b1;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= bus.div) begin
                    // >= so that lowering div below cnt fires at once instead of wrapping
                    cpu_ce_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            PULSE: state_d = RELEASE;
            RELEASE: begin
                if (run_s) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (!step_db) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            run_sync_q     <= '0;
            step_sync_q    <= '0;
            step_db_prev_q <= 1'b0;
            cpu_ce_q       <= 1'b0;
            cpu_clk_q      <= 1'b0;
            ce_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_sync_q     <= run_sync_d;
            step_sync_q    <= step_sync_d;
            step_db_prev_q <= step_db_prev_d;
            cpu_ce_q       <= cpu_ce_d;
            cpu_clk_q      <= cpu_clk_d;
            ce_count_q     <= ce_count_d;
        end
    end

    assign bus.cpu_ce   = cpu_ce_q;
    assign bus.cpu_clk  = cpu_clk_q;
    assign bus.ce_count = ce_count_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_clock_ctrl;
    localparam int unsigned DIV_W = 21;
    localparam int unsigned DB    = 4;
`ifdef CLKCTL_DEBOUNCE_EN
    localparam int LAT = 2 + DB + 1;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_ctrl_if #(.DIV_W(DIV_W)) bus ();

    clock_ctrl #(.DIV_W(DIV_W), .DB_CYCLES(DB), .DB_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference: flags for "free running", "just stepped", "waiting for release"
    bit        m_ce, m_clk;
    bit [15:0] m_count;
    bit [1:0]  m_run_sh, m_step_sh;
    bit        m_db, m_db_prev, m_free, m_stepped, m_waiting;
    int        m_gap, m_dbc;

    always @(posedge clk or posedge rst) begin
        bit run_s, step_s, nce, old_db;
        if (rst) begin
            m_ce = 0; m_clk = 0; m_count = 0; m_run_sh = 0; m_step_sh = 0;
            m_db = 0; m_db_prev = 0; m_free = 0; m_stepped = 0; m_waiting = 0;
            m_gap = 0; m_dbc = 0;
        end else begin
            run_s  = m_run_sh[1];
            step_s = m_step_sh[1];
            old_db = m_db;
            nce    = 0;
            if (m_free) begin
                if (!run_s) begin m_free = 0; m_gap = 0; end
                else begin
                    nce   = (m_gap >= int'(bus.div));
                    m_gap = nce ? 0 : m_gap + 1;
                end
            end else if (m_stepped) begin
                m_stepped = 0; m_waiting = 1;
            end else if (m_waiting) begin
                if (run_s) begin m_waiting = 0; m_free = 1; m_gap = 0; end
                else if (!old_db) m_waiting = 0;
            end else begin
                if (run_s) begin m_free = 1; m_gap = 0; end
                else if (old_db && !m_db_prev) begin m_stepped = 1; nce = 1; end
            end
            if (m_ce) begin m_clk = !m_clk; m_count = m_count + 16'd1; end
            m_ce = nce;
            m_db_prev = old_db;
`ifdef CLKCTL_DEBOUNCE_EN
            if (step_s != m_db) begin
                m_dbc++;
                if (m_dbc >= int'(DB)) begin m_db = step_s; m_dbc = 0; end
            end else m_dbc = 0;
`endif
            m_run_sh  = {m_run_sh[0], bus.run};
            m_step_sh = {m_step_sh[0], bus.step};
`ifndef CLKCTL_DEBOUNCE_EN
            m_db = m_step_sh[1];
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.div = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int guard = 0;
        do_reset();
        bus.div = DIV_W'(2); bus.run = 1'b1;
        repeat (10) tick();
        while (bus.cpu_ce !== 1'b1 && guard < 20) begin tick(); guard++; end
        n_tests++;
        if (guard >= 20) begin n_fail++; $display("FAIL reset_setup: no pulse seen before reset"); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.cpu_ce, bus.cpu_clk, bus.ce_count} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_async: got ce=%0b clk=%0b cnt=%0d expected all 0", bus.cpu_ce, bus.cpu_clk, bus.ce_count);
        end
        bus.run = 1'b0;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick();
            n_tests++;
            if (bus.cpu_ce !== 1'b0 || bus.ce_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d: got ce=%0b cnt=%0d expected 0/0", t, bus.cpu_ce, bus.ce_count);
            end
        end
    endtask

    task automatic test_freerun();
        int pulses = 0, last = 0, t = 0;
        do_reset();
        bus.div = DIV_W'(3); bus.run = 1'b1;
        while (pulses < 40 && t < 1000) begin
            tick(); t++;
            if (bus.cpu_ce === 1'b1) begin
                pulses++;
                n_tests++;
                if (pulses == 1 && t != 7) begin
                    n_fail++; $display("FAIL freerun_first: got tick %0d expected 7", t);
                end else if (pulses > 1 && t - last != 4) begin
                    n_fail++; $display("FAIL freerun_period: got %0d expected 4", t - last);
                end
                last = t;
            end
        end
        n_tests++;
        if (pulses != 40) begin n_fail++; $display("FAIL freerun_timeout: got %0d pulses expected 40", pulses); end
        tick();
        n_tests++;
        if (bus.ce_count !== 16'd40 || bus.cpu_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL freerun_count: got cnt=%0d clk=%0b expected 40/0", bus.ce_count, bus.cpu_clk);
        end
    endtask

    task automatic test_div_zero();
        do_reset();
        bus.div = '0; bus.run = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            n_tests++;
            if (bus.cpu_ce !== (t >= 4)) begin
                n_fail++; $display("FAIL div0_ce t=%0d: got %0b expected %0b", t, bus.cpu_ce, t >= 4);
            end
        end
        n_tests++;
        if (bus.ce_count !== 16'd20 || bus.cpu_clk !== 1'b0) begin
            n_fail++; $display("FAIL div0_count: got cnt=%0d clk=%0b expected 20/0", bus.ce_count, bus.cpu_clk);
        end
    endtask

    task automatic test_div_change();
        bit exp;
        do_reset();
        bus.div = DIV_W'(10); bus.run = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            exp = (t >= 11) && ((t - 11) % 3 == 0);
            n_tests++;
            if (bus.cpu_ce !== exp) begin
                n_fail++; $display("FAIL divchg_ce t=%0d: got %0b expected %0b", t, bus.cpu_ce, exp);
            end
            if (t == 10) bus.div = DIV_W'(2);
        end
        n_tests++;
        if (bus.ce_count !== 16'd3) begin
            n_fail++; $display("FAIL divchg_count: got %0d expected 3", bus.ce_count);
        end
    endtask

    task automatic test_single_step();
        do_reset();
        bus.step = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_tests++;
            if (bus.cpu_ce !== (t == LAT)) begin
                n_fail++; $display("FAIL step_ce t=%0d: got %0b expected %0b", t, bus.cpu_ce, t == LAT);
            end
            if (t == 20) bus.step = 1'b0;
        end
        n_tests++;
        if (bus.ce_count !== 16'd1) begin
            n_fail++; $display("FAIL step_count: got %0d expected 1", bus.ce_count);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0, pulses_first = 0;
        do_reset();
        for (int t = 0; t < 170; t++) begin
            if (t < 30)       bus.step = (((t >> 1) & 1) == 0);
            else if (t < 70)  bus.step = 1'b1;
            else if (t < 110) bus.step = 1'b0;
            else if (t < 150) bus.step = 1'b1;
            else              bus.step = 1'b0;
            tick();
            if (bus.cpu_ce === 1'b1) pulses++;
            if (t == 109) pulses_first = pulses;
            n_tests++;
            if (bus.cpu_ce !== m_ce) begin
                n_fail++; $display("FAIL bounce_ce t=%0d: got %0b expected %0b", t, bus.cpu_ce, m_ce);
            end
        end
`ifdef CLKCTL_DEBOUNCE_EN
        n_tests++;
        if (pulses_first != 1 || pulses != 2) begin
            n_fail++; $display("FAIL bounce_pulses: got %0d/%0d expected 1/2", pulses_first, pulses);
        end
`endif
        n_tests++;
        if (bus.ce_count !== m_count) begin
            n_fail++; $display("FAIL bounce_count: got %0d expected %0d", bus.ce_count, m_count);
        end
    endtask

    task automatic test_mode_switch();
        bit exp;
        do_reset();
        bus.div = DIV_W'(3); bus.step = 1'b1;
        for (int t = 1; t <= LAT + 14; t++) begin
            tick();
            exp = (t == LAT) || (t >= LAT + 6 && ((t - LAT - 6) % 4 == 0));
            n_tests++;
            if (bus.cpu_ce !== exp) begin
                n_fail++; $display("FAIL mode_ce t=%0d: got %0b expected %0b", t, bus.cpu_ce, exp);
            end
            if (t == LAT + 1 || t == LAT + 6) begin
                n_tests++;
                if (bus.ce_count !== 16'd1) begin
                    n_fail++; $display("FAIL mode_count t=%0d: got %0d expected 1", t, bus.ce_count);
                end
            end
            if (t == LAT - 2) bus.run = 1'b1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 99) < 2) bus.run = ~bus.run;
            if ($urandom_range(0, 99) < 5) bus.step = ~bus.step;
            if ($urandom_range(0, 99) < 3) bus.div = DIV_W'($urandom_range(0, 7));
            tick();
            n_tests++;
            if (bus.cpu_ce !== m_ce || bus.cpu_clk !== m_clk || bus.ce_count !== m_count) begin
                n_fail++;
                $display("FAIL random t=%0d: got ce=%0b clk=%0b cnt=%0d expected %0b/%0b/%0d",
                         t, bus.cpu_ce, bus.cpu_clk, bus.ce_count, m_ce, m_clk, m_count);
            end
        end
    endtask

    initial begin
        bus.run = 1'b0; bus.step = 1'b0; bus.div = '0;
        #1;
        test_reset();
        test_freerun();
        test_div_zero();
        test_div_change();
        test_single_step();
        test_bounce();
        test_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
